// File: rtl/input_arbiter_pkg.sv
// Shared ownership encoding and default timing constants for the pad/autopilot arbiter.
package input_arbiter_pkg;

   typedef enum logic [1:0] {
      OWN_AI     = 2'd0,
      OWN_HUMAN  = 2'd1,
      OWN_SWITCH = 2'd2
   } owner_e;

   localparam int unsigned IDLE_TIMEOUT_DEFAULT  = 600;
   localparam int unsigned JUMP_HOLD_DEFAULT     = 4;
   localparam int unsigned RESTART_DELAY_DEFAULT = 60;

endpackage

// File: rtl/input_arbiter_counter.sv
// Loadable down-counter stepped by frame ticks; exposes whether its next value is zero.
module frame_down_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         tick_i,
   output logic         zero_d_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Priority: clear, then load, then decrement.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (tick_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_d_o = (cnt_d == '0);

endmodule

// File: rtl/input_arbiter.sv
// Arbitrates game buttons between gamepad and autopilot with idle handover,
// jump hold stretching and post-crash restart delay.
module input_arbiter
   import input_arbiter_pkg::*;
#(
   parameter int unsigned IDLE_TIMEOUT  = IDLE_TIMEOUT_DEFAULT,
   parameter int unsigned JUMP_HOLD     = JUMP_HOLD_DEFAULT,
   parameter int unsigned RESTART_DELAY = RESTART_DELAY_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic frame_tick,
   input  logic gamepad_is_present,
   input  logic pad_start,
   input  logic pad_up,
   input  logic pad_down,
   input  logic ai_start,
   input  logic ai_up,
   input  logic ai_down,
   input  logic crash,
   output logic button_start,
   output logic button_up,
   output logic button_down,
   output logic human_owner
);

   owner_e      state_q, state_d;
   owner_e      target_q, target_d;
   logic [15:0] idle_q, idle_d;
   logic        crash_q;
   logic        src_start, src_up, src_down;
   logic        pad_any, leave;
   logic        hold_zero_d, rst_zero_d;
   logic        start_q, start_d, up_q, up_d, down_q, down_d, owner_q, owner_d;

   assign pad_any = pad_start | pad_up | pad_down;

   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      idle_d    = '0;
      leave     = 1'b0;
      src_start = 1'b0;
      src_up    = 1'b0;
      src_down  = 1'b0;
      case (state_q)
         OWN_AI: begin
            src_start = ai_start;
            src_up    = ai_up;
            src_down  = ai_down;
            if (gamepad_is_present && pad_any) begin
               leave    = 1'b1;
               state_d  = OWN_SWITCH;
               target_d = OWN_HUMAN;
            end
         end
         OWN_HUMAN: begin
            src_start = pad_start;
            src_up    = pad_up;
            src_down  = pad_down;
            if (pad_any) begin
               idle_d = '0;
            end else if (frame_tick && (idle_q != '1)) begin
               idle_d = idle_q + 16'd1;
            end else begin
               idle_d = idle_q;
            end
            // Timeout is judged on the updated count so it fires on the counting edge.
            if (!gamepad_is_present || (32'(idle_d) >= 32'(IDLE_TIMEOUT))) begin
               leave    = 1'b1;
               state_d  = OWN_SWITCH;
               target_d = OWN_AI;
            end
         end
         OWN_SWITCH: state_d = target_q;
         default:    state_d = OWN_AI;
      endcase
   end

   frame_down_counter #(.W(8)) u_hold (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (state_q == OWN_SWITCH),
      .load_i     (src_up & ~leave),
      .load_val_i (8'(JUMP_HOLD)),
      .tick_i     (frame_tick),
      .zero_d_o   (hold_zero_d)
   );

   frame_down_counter #(.W(8)) u_restart (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (state_q != OWN_AI),
      .load_i     ((state_q == OWN_AI) & crash & ~crash_q & ~leave),
      .load_val_i (8'(RESTART_DELAY)),
      .tick_i     (frame_tick),
      .zero_d_o   (rst_zero_d)
   );

   // Restart counter is held at zero outside AI, so the gate only bites for autopilot.
   always_comb begin
      up_d    = src_up | ~hold_zero_d;
      down_d  = src_down & ~up_d;
      start_d = src_start & rst_zero_d;
      owner_d = (state_d == OWN_HUMAN);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= OWN_AI;
         target_q <= OWN_AI;
         idle_q   <= '0;
         crash_q  <= 1'b0;
         start_q  <= 1'b0;
         up_q     <= 1'b0;
         down_q   <= 1'b0;
         owner_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         idle_q   <= idle_d;
         crash_q  <= crash;
         start_q  <= start_d;
         up_q     <= up_d;
         down_q   <= down_d;
         owner_q  <= owner_d;
      end
   end

   assign button_start = start_q;
   assign button_up    = up_q;
   assign button_down  = down_q;
   assign human_owner  = owner_q;

endmodule

// File: doc/input_arbiter.md
# input_arbiter

Arbitrates game control between the human gamepad and the AI autopilot, then drives the three button lines (start, up, down) into the game core. It owns a small ownership FSM with an idle-timeout handover back to the AI and a one-cycle dead switch state. It also provides frame-based jump hold stretching and a post-crash restart delay for autopilot play. It sits between the gamepad decoder/autopilot and the game state logic.

## Interface
Parameters:
- IDLE_TIMEOUT, default 600: frame ticks without any pad press before ownership returns to AI; range 1..65535.
- JUMP_HOLD, default 4: minimum frame ticks button_up stays high after the source up drops; range 0..255.
- RESTART_DELAY, default 60: frame ticks after an AI-owned crash before ai_start is passed; range 0..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- frame_tick  in  1  one-clk pulse per video frame
- gamepad_is_present  in  1  pad connected
- pad_start / pad_up / pad_down  in  1 each  human buttons
- ai_start / ai_up / ai_down  in  1 each  autopilot buttons
- crash  in  1  level, high while the player is crashed
- button_start / button_up / button_down  out  1 each  registered arbitrated buttons
- human_owner  out  1  registered; 1 = HUMAN state, 0 otherwise

## Operation
- States: AI (reset state), HUMAN, SWITCH. SWITCH stores a target (AI or HUMAN).
- AI -> SWITCH(target HUMAN) when gamepad_is_present and any pad button is high.
- HUMAN -> SWITCH(target AI) when gamepad_is_present=0, or when idle_cnt reaches IDLE_TIMEOUT.
- SWITCH lasts exactly one clk, then moves to its target.
- idle_cnt is 16 bits and is active only in HUMAN:
  - cleared on any pad press;
  - otherwise incremented on frame_tick;
  - saturates;
  - cleared on every entry to HUMAN.
- Source select: AI state uses the ai_* inputs, HUMAN uses the pad_* inputs, SWITCH forces all sources to 0.
- Up hold, hold_cnt 8 bits:
  - src_up=1 loads hold_cnt with JUMP_HOLD.
  - Otherwise, frame_tick with hold_cnt>0 decrements it.
  - button_up = src_up | (hold_cnt≠0).
- Down is suppressed while the next button_up is 1 (up wins).
- Restart delay, rst_cnt 8 bits, AI state only:
  - The crash rising edge (crash & ~crash_q) loads RESTART_DELAY.
  - frame_tick with rst_cnt>0 decrements it.
  - button_start = ai_start & (rst_cnt==0).
- In HUMAN, button_start = pad_start with no delay.
- SWITCH clears hold_cnt, rst_cnt and idle_cnt.
- Simultaneous events:
  - A state transition out of AI/HUMAN takes priority over all counter loads in that cycle.
  - Crash edge and frame_tick in the same cycle: load wins.
  - src_up and frame_tick in the same cycle: load wins.
- Reset, including mid-operation:
  - state=AI, all counters 0, crash_q=0;
  - all outputs 0, human_owner=0.

## Timing
- All outputs are registered: one clk latency from any input to its button.
- Ownership change: the press is sampled at edge N, SWITCH is entered at N, the target state is reached at N+1. Buttons are 0 for clk N+1 and follow the new source from N+2.
- Jump stretch: button_up falls on the clk after the JUMP_HOLD-th frame_tick following src_up's fall. With JUMP_HOLD=0 it falls one clk after src_up.
- Idle timeout fires on the clk at which the IDLE_TIMEOUT-th idle frame_tick is counted.
- gamepad_is_present drop: exit from HUMAN on the next clk edge, independent of idle_cnt.

## Structure
- Shared package holds:
  - the owner state encoding (AI=2'd0, HUMAN=2'd1, SWITCH=2'd2);
  - default constants IDLE_TIMEOUT, JUMP_HOLD, RESTART_DELAY, which the game top and the autopilot share.
- One natural sub-module: frame_down_counter (loadable, decrement on tick, zero flag). It is instantiated twice, for hold_cnt and rst_cnt.
- The FSM, idle_cnt and output mux stay in input_arbiter.

## Test plan
- Reset, then ai_up=1 for 1 clk with JUMP_HOLD=4 → button_up high for the 1 clk plus until 4 frame_ticks have elapsed; human_owner=0.
- In AI, pad_up=1 with gamepad_is_present=1 → one clk of all-zero buttons, then human_owner=1 and button_up tracks pad_up.
- In HUMAN with IDLE_TIMEOUT=3, no presses for 3 frame_ticks → SWITCH, then AI. A press at tick 2 instead restarts the count.
- In AI, crash rises with ai_start=1 held and RESTART_DELAY=5 → button_start stays 0 for 5 frame_ticks, then goes 1.
- ai_up=1 and ai_down=1 together → button_up=1, button_down=0. After the hold expires with down still high → button_down=1.
- gamepad_is_present drops in HUMAN in the same clk as a crash edge → SWITCH is taken and rst_cnt stays 0. rst_n low mid-hold → all outputs 0 next clk.
